// File: rtl/ps2_byte_receiver_if.sv
// Byte-side handshake between the PS/2 receiver and the mouse master FSM.
// The master drives READ_ENABLE. The receiver returns each byte, its error code
// and a one-cycle ready strobe.
interface ps2_byte_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: start, 8 data bits LSB first, odd parity, stop.
// The PS/2 clock line is shared with the transmitter, so it is only ever sampled here.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (falling PS/2 clock with data low)
//   DATA   | shifting in data bits 0..7
//   PARITY | waiting for the parity bit
//   STOP   | waiting for the stop bit, then publish byte and strobe
module ps2_byte_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CLK_MOUSE_IN,
  input  logic               DATA_MOUSE_IN,
  ps2_byte_receiver_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DATA   = 4'b0010,
    PARITY = 4'b0100,
    STOP   = 4'b1000
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_hist;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [TW-1:0]          timeout_cnt;
  logic [7:0]             shift_reg;
  logic                   parity_bit;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_hist & ~clk_s;

  // Synchronise both raw lines and keep one cycle of clock history; preset to idle-bus level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], CLK_MOUSE_IN};
      data_sync <= {data_sync[SYNC_STAGES-2:0], DATA_MOUSE_IN};
      clk_hist  <= clk_s;
    end
  end

  // Frame FSM with registered outputs; disable beats timeout, timeout beats a falling edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state               <= IDLE;
      bit_cnt             <= '0;
      timeout_cnt         <= '0;
      shift_reg           <= '0;
      parity_bit          <= 1'b0;
      bus.BYTE_READ       <= 8'h00;
      bus.BYTE_ERROR_CODE <= 2'b00;
      bus.BYTE_READY      <= 1'b0;
    end else begin
      bus.BYTE_READY <= 1'b0;
      if (!bus.READ_ENABLE) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        timeout_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            timeout_cnt <= '0;
            if (fall && !data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA, PARITY, STOP: begin
            if (timeout_cnt == TIMEOUT_LAST) begin
              state       <= IDLE;
              timeout_cnt <= '0;
            end else if (fall) begin
              timeout_cnt <= '0;
              case (state)
                DATA: begin
                  shift_reg[bit_cnt] <= data_s;
                  bit_cnt            <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: begin
                  parity_bit <= data_s;
                  state      <= STOP;
                end
                default: begin
                  bus.BYTE_READ          <= shift_reg;
                  bus.BYTE_ERROR_CODE[0] <= ~(^{shift_reg, parity_bit});
                  bus.BYTE_ERROR_CODE[1] <= ~data_s;
                  bus.BYTE_READY         <= 1'b1;
                  state                  <= IDLE;
                end
              endcase
            end else begin
              timeout_cnt <= timeout_cnt + TW'(1);
            end
          end
          default: begin
            state       <= IDLE;
            timeout_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed bench for ps2_byte_receiver with a shortened PS/2 bit time and timeout.
module tb_ps2_byte_receiver;
  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int stop_cycle = 0;
  int strobe_cycle = 0;
  int strobes = 0;
  int doubles = 0;
  bit prev_ready = 1'b0;
  logic [7:0] q_byte[$];
  logic [1:0] q_code[$];

  ps2_byte_receiver_if rx_if();

  ps2_byte_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .CLK_MOUSE_IN(ps2_clk),
    .DATA_MOUSE_IN(ps2_data),
    .bus(rx_if)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle++;

  always @(negedge CLK) begin
    if (rx_if.BYTE_READY === 1'b1) begin
      strobes++;
      strobe_cycle = cycle;
      q_byte.push_back(rx_if.BYTE_READ);
      q_code.push_back(rx_if.BYTE_ERROR_CODE);
      if (prev_ready) doubles++;
    end
    prev_ready = (rx_if.BYTE_READY === 1'b1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ps2_bit(input logic b, input bit is_stop);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    if (is_stop) stop_cycle = cycle;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; READ_ENABLE is dropped before bit index drop_at.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int drop_at, input int nbits);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) rx_if.READ_ENABLE = 1'b0;
      ps2_bit(fr[i], i == 10);
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic check_frame(input string name, input int s0, input logic [7:0] exp_b,
                             input logic [1:0] exp_c);
    vectors++;
    if (strobes - s0 !== 1) begin
      miscompares++;
      $display("FAIL %s strobe count: got %0d expected 1", name, strobes - s0);
    end
    vectors++;
    if (rx_if.BYTE_READ !== exp_b) begin
      miscompares++;
      $display("FAIL %s byte: got %h expected %h", name, rx_if.BYTE_READ, exp_b);
    end
    vectors++;
    if (rx_if.BYTE_ERROR_CODE !== exp_c) begin
      miscompares++;
      $display("FAIL %s code: got %b expected %b", name, rx_if.BYTE_ERROR_CODE, exp_c);
    end
  endtask

  task automatic test_reset();
    rx_if.READ_ENABLE = 1'b1;
    wait_cycles(3);
    vectors++;
    if (rx_if.BYTE_READ !== 8'h00) begin
      miscompares++;
      $display("FAIL reset byte: got %h expected 00", rx_if.BYTE_READ);
    end
    vectors++;
    if (rx_if.BYTE_ERROR_CODE !== 2'b00) begin
      miscompares++;
      $display("FAIL reset code: got %b expected 00", rx_if.BYTE_ERROR_CODE);
    end
    vectors++;
    if (rx_if.BYTE_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ready: got %b expected 0", rx_if.BYTE_READY);
    end
    RESET = 1'b1;
    wait_cycles(5);
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL reset idle strobes: got %0d expected 0", strobes);
    end
  endtask

  task automatic test_good_frame();
    int s0;
    s0 = strobes;
    send_frame(8'hFA, 1'b1, 1'b1, -1, 11);
    check_frame("good_FA", s0, 8'hFA, 2'b00);
    vectors++;
    if (strobe_cycle - stop_cycle !== SYNC + 1) begin
      miscompares++;
      $display("FAIL latency: got %0d expected %0d", strobe_cycle - stop_cycle, SYNC + 1);
    end
  endtask

  task automatic test_errors();
    int s0;
    s0 = strobes;
    send_frame(8'hAA, 1'b0, 1'b1, -1, 11);
    check_frame("parity_err", s0, 8'hAA, 2'b01);
    s0 = strobes;
    send_frame(8'h08, 1'b0, 1'b0, -1, 11);
    check_frame("stop_err", s0, 8'h08, 2'b10);
  endtask

  task automatic test_timeout();
    int s0;
    s0 = strobes;
    send_frame(8'hAA, 1'b1, 1'b1, -1, 6);
    wait_cycles(3 * TMO);
    vectors++;
    if (strobes !== s0) begin
      miscompares++;
      $display("FAIL timeout strobe: got %0d expected %0d", strobes, s0);
    end
    vectors++;
    if (rx_if.BYTE_READ !== 8'h08 || rx_if.BYTE_ERROR_CODE !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout hold: got %h/%b expected 08/10", rx_if.BYTE_READ, rx_if.BYTE_ERROR_CODE);
    end
    s0 = strobes;
    send_frame(8'hAA, 1'b1, 1'b1, -1, 11);
    check_frame("after_timeout", s0, 8'hAA, 2'b00);
  endtask

  task automatic test_read_enable();
    int s0;
    s0 = strobes;
    rx_if.READ_ENABLE = 1'b0;
    send_frame(8'h14, 1'b1, 1'b1, -1, 11);
    vectors++;
    if (strobes !== s0 || rx_if.BYTE_READ !== 8'hAA) begin
      miscompares++;
      $display("FAIL disabled frame: got %0d strobes byte %h expected 0 strobes byte aa",
               strobes - s0, rx_if.BYTE_READ);
    end
    rx_if.READ_ENABLE = 1'b1;
    wait_cycles(5);
    send_frame(8'h14, 1'b1, 1'b1, 9, 11);
    vectors++;
    if (strobes !== s0) begin
      miscompares++;
      $display("FAIL drop at parity: got %0d strobes expected 0", strobes - s0);
    end
    rx_if.READ_ENABLE = 1'b1;
    wait_cycles(5);
    send_frame(8'h14, 1'b1, 1'b1, -1, 11);
    check_frame("reenabled_14", s0, 8'h14, 2'b00);
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    send_frame(8'hF4, 1'b0, 1'b1, -1, 5);
    #2;
    RESET = 1'b0;
    #1;
    vectors++;
    if (rx_if.BYTE_READ !== 8'h00 || rx_if.BYTE_ERROR_CODE !== 2'b00 || rx_if.BYTE_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL mid reset outputs: got %h/%b/%b expected 00/00/0",
               rx_if.BYTE_READ, rx_if.BYTE_ERROR_CODE, rx_if.BYTE_READY);
    end
    wait_cycles(3);
    RESET = 1'b1;
    wait_cycles(5);
    s0 = strobes;
    send_frame(8'hF4, 1'b0, 1'b1, -1, 11);
    check_frame("after_reset_F4", s0, 8'hF4, 2'b00);
  endtask

  task automatic test_back_to_back();
    int s0;
    int d0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h08;
    exp_b[1] = 8'h05;
    exp_b[2] = 8'hFB;
    q_byte.delete();
    q_code.delete();
    s0 = strobes;
    d0 = doubles;
    send_frame(8'h08, 1'b0, 1'b1, -1, 11);
    wait_cycles(HALF);
    send_frame(8'h05, 1'b1, 1'b1, -1, 11);
    wait_cycles(HALF);
    send_frame(8'hFB, 1'b0, 1'b1, -1, 11);
    vectors++;
    if (strobes - s0 !== 3 || q_byte.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b strobe count: got %0d expected 3", strobes - s0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (q_byte[i] !== exp_b[i] || q_code[i] !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b byte %0d: got %h/%b expected %h/00", i, q_byte[i], q_code[i], exp_b[i]);
        end
      end
    end
    vectors++;
    if (doubles !== d0) begin
      miscompares++;
      $display("FAIL b2b strobe width: got %0d wide strobes expected 0", doubles - d0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_read_enable();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
